spi_slave_nword: RTL

- Parametrised successor to the two-word SPI readback slave; runs in the system clock domain rather than clocking logic from sck.
- sck, cs_n and mosi are oversampled through synchronisers.
- Shifts out an N_WORDS x WORD_W status frame, snapshotted at frame start, and captures an equal-length MOSI control frame.
- Sits between the board controller SPI master and the sync/status logic.
- Adds length checking, an error pulse and a frame counter.

---
 rtl/spi_slave_nword_if.sv | 18 +
 rtl/spi_slave_nword.sv | 128 ++++++++++++
 2 files changed

// File: rtl/spi_slave_nword_if.sv
// spi_slave_nword_if: SPI pins plus parallel status/control frame side of the N-word SPI slave
interface spi_slave_nword_if #(
  parameter int FL = 64,
  parameter int CNT_W = 16
);
  logic sck, cs_n, mosi, miso, miso_oe;
  logic [FL-1:0] tx_data, rx_data;
  logic rx_valid, frame_err, busy;
  logic [CNT_W-1:0] frame_cnt;
  modport slave (
    input sck, cs_n, mosi, tx_data,
    output miso, miso_oe, rx_data, rx_valid, frame_err, frame_cnt, busy
  );
  modport master (
    output sck, cs_n, mosi, tx_data,
    input miso, miso_oe, rx_data, rx_valid, frame_err, frame_cnt, busy
  );
endinterface

// File: rtl/spi_slave_nword.sv
// spi_slave_nword: oversampled mode-0 SPI slave shifting out a snapshotted N-word status frame
// while capturing an equal-length control frame, with length check, error pulse and frame counter.
module spi_slave_nword #(
  parameter int WORD_W = 32,
  parameter int N_WORDS = 2,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  spi_slave_nword_if.slave bus
);
  localparam int FL = WORD_W * N_WORDS;
  localparam int BW = $clog2(FL + 2);
  localparam logic [BW-1:0] FL_C = BW'(FL);
  localparam logic [BW-1:0] SAT_C = BW'(FL + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][2:0] sy_q, sy_d;
  logic [SYNC_STAGES:0] vld_q, vld_d;
  logic [1:0] prev_q, prev_d;
  logic armed_q, armed_d, pend_q, pend_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [FL-2:0] tx_q, tx_d;
  logic [FL-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic miso_q, miso_d, oe_q, oe_d, rx_valid_q, rx_valid_d, err_q, err_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_rise, cs_fall;
  assign {sck_s, cs_s, mosi_s} = sy_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~prev_q[1];
  assign sck_fall = ~sck_s & prev_q[1];
  assign cs_rise = cs_s & ~prev_q[0];
  assign cs_fall = ~cs_s & prev_q[0];
  always_comb begin
    sy_d = {sy_q[SYNC_STAGES-2:0], bus.sck, bus.cs_n, bus.mosi};
    vld_d = {vld_q[SYNC_STAGES-1:0], 1'b1};
    prev_d = {sck_s, cs_s};
    // a frame may only start once cs_n has been seen high on real (post-reset) samples
    armed_d = armed_q | (vld_q[SYNC_STAGES] & cs_s);
    pend_d = pend_q;
    state_d = state_q;
    cnt_d = cnt_q;
    tx_d = tx_q;
    rx_sh_d = rx_sh_q;
    rx_data_d = rx_data_q;
    miso_d = miso_q;
    oe_d = oe_q;
    rx_valid_d = 1'b0;
    err_d = 1'b0;
    fcnt_d = fcnt_q;
    case (state_q)
      IDLE: if ((cs_fall | pend_q) & armed_q) begin
        state_d = SHIFT;
        tx_d = bus.tx_data[FL-2:0];
        miso_d = bus.tx_data[FL-1];
        oe_d = 1'b1;
        cnt_d = '0;
        rx_sh_d = '0;
        pend_d = 1'b0;
      end
      SHIFT: if (cs_rise) begin
        state_d = CHECK;
        oe_d = 1'b0;
        miso_d = 1'b0;
      end else begin
        if (sck_rise) begin
          rx_sh_d = {rx_sh_q[FL-2:0], mosi_s};
          cnt_d = cnt_q == SAT_C ? cnt_q : cnt_q + 1'b1;
        end
        if (sck_fall) begin
          tx_d = {tx_q[FL-3:0], 1'b0};
          miso_d = cnt_q < FL_C ? tx_q[FL-2] : 1'b0;
        end
      end
      CHECK: begin
        state_d = IDLE;
        pend_d = cs_fall;
        if (cnt_q == FL_C) begin
          rx_data_d = rx_sh_q;
          rx_valid_d = 1'b1;
          fcnt_d = fcnt_q + 1'b1;
        end else err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sy_q <= {SYNC_STAGES{3'b010}};
      vld_q <= '0;
      prev_q <= 2'b01;
      armed_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q <= '0;
      tx_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
      miso_q <= 1'b0;
      oe_q <= 1'b0;
      rx_valid_q <= 1'b0;
      err_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      state_q <= state_d;
      sy_q <= sy_d;
      vld_q <= vld_d;
      prev_q <= prev_d;
      armed_q <= armed_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      tx_q <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
      miso_q <= miso_d;
      oe_q <= oe_d;
      rx_valid_q <= rx_valid_d;
      err_q <= err_d;
      fcnt_q <= fcnt_d;
    end
  assign bus.miso = miso_q;
  assign bus.miso_oe = oe_q;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.frame_err = err_q;
  assign bus.frame_cnt = fcnt_q;
  assign bus.busy = state_q == SHIFT;
endmodule
